// File: rtl/exc_ctrl_if.sv
// exc_ctrl_if: MEM-stage event, CP0 context and fetch-redirect signals of the exception controller.
interface exc_ctrl_if;
  logic        mem_valid_i, mem_delayslot_i;
  logic        mem_break_i, mem_syscall_i, mem_overflow_i, mem_ades_i, mem_adel_i, mem_eret_i;
  logic [31:0] mem_pc_i, mem_addr_i;
  logic [31:0] cp0_status_i, cp0_cause_i, cp0_epc_i;
  logic [5:0]  int_i;
  logic        timer_int_i, redirect_ready_i;
  logic        exc_int_o, exc_break_o, exc_syscall_o, exc_overflow_o, exc_ades_o, exc_adel_o, exc_eret_o;
  logic        exc_delayslot_o, stall_o, flush_o, redirect_valid_o;
  logic [31:0] exc_pc_o, exc_badvaddr_o, redirect_pc_o;
  modport master (
    output mem_valid_i, mem_delayslot_i, mem_break_i, mem_syscall_i, mem_overflow_i, mem_ades_i,
           mem_adel_i, mem_eret_i, mem_pc_i, mem_addr_i, cp0_status_i, cp0_cause_i, cp0_epc_i,
           int_i, timer_int_i, redirect_ready_i,
    input  exc_int_o, exc_break_o, exc_syscall_o, exc_overflow_o, exc_ades_o, exc_adel_o, exc_eret_o,
           exc_delayslot_o, stall_o, flush_o, redirect_valid_o, exc_pc_o, exc_badvaddr_o, redirect_pc_o
  );
  modport slave (
    input  mem_valid_i, mem_delayslot_i, mem_break_i, mem_syscall_i, mem_overflow_i, mem_ades_i,
           mem_adel_i, mem_eret_i, mem_pc_i, mem_addr_i, cp0_status_i, cp0_cause_i, cp0_epc_i,
           int_i, timer_int_i, redirect_ready_i,
    output exc_int_o, exc_break_o, exc_syscall_o, exc_overflow_o, exc_ades_o, exc_adel_o, exc_eret_o,
           exc_delayslot_o, stall_o, flush_o, redirect_valid_o, exc_pc_o, exc_badvaddr_o, redirect_pc_o
  );
endinterface

// File: rtl/exc_ctrl.sv
// exc_ctrl: arbitrates MEM-stage exceptions/interrupts/eret, flushes the pipeline, then redirects fetch.
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int          FLUSH_CYCLES = 2
) (
  input logic       clk,
  input logic       rst,
  exc_ctrl_if.slave b
);
  typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;
  state_t      state, state_nx;
  logic [3:0]  cnt;
  logic        int_pend, accept;
  logic [6:0]  req, grant, pulse;
  logic        ds_q;
  logic [31:0] pc_q, bad_q, rpc_q;
  logic        unused_ok;
  assign int_pend = (|({b.int_i[5] | b.timer_int_i, b.int_i[4:0], b.cp0_cause_i[9:8]} & b.cp0_status_i[15:8]))
                    && b.cp0_status_i[0] && !b.cp0_status_i[1];
  // lsb is highest priority so the lowest set bit is the winner
  assign req = {b.mem_eret_i, b.mem_adel_i, b.mem_ades_i, b.mem_overflow_i, b.mem_syscall_i, b.mem_break_i, int_pend};
  assign grant = req & (~req + 7'd1);
  assign accept = state == IDLE && b.mem_valid_i && |req;
  assign b.stall_o = accept || state != IDLE;
  assign b.flush_o = state == FLUSH;
  assign b.redirect_valid_o = state == REDIRECT;
  assign {b.exc_eret_o, b.exc_adel_o, b.exc_ades_o, b.exc_overflow_o, b.exc_syscall_o, b.exc_break_o, b.exc_int_o} = pulse;
  assign b.exc_pc_o = pc_q;
  assign b.exc_delayslot_o = ds_q;
  assign b.exc_badvaddr_o = bad_q;
  assign b.redirect_pc_o = rpc_q;
  assign unused_ok = &{1'b0, b.cp0_status_i[31:16], b.cp0_status_i[7:2], b.cp0_cause_i[31:10], b.cp0_cause_i[7:0]};
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE  ? (accept ? FLUSH : IDLE)
             : state == FLUSH ? (cnt == 4'd1 ? REDIRECT : FLUSH)
             : (b.redirect_ready_i ? IDLE : REDIRECT);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      pulse <= '0;
      pc_q  <= '0;
      ds_q  <= 1'b0;
      bad_q <= '0;
      rpc_q <= '0;
    end else begin
      state <= state_nx;
      cnt   <= accept ? 4'(FLUSH_CYCLES) : state == FLUSH ? cnt - 4'd1 : cnt;
      pulse <= accept ? grant : '0;
      if (accept) begin
        pc_q  <= b.mem_pc_i;
        ds_q  <= b.mem_delayslot_i;
        bad_q <= b.mem_addr_i;
        rpc_q <= grant[6] ? b.cp0_epc_i : EXC_VECTOR;
      end
    end
  end
endmodule

// File: doc/exc_ctrl.md
EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 Parameter EXC_VECTOR, default 32'hBFC00380, exception entry PC.
REQ-002 Parameter FLUSH_CYCLES, default 2, number of cycles flush_o is held (range 1..15).
REQ-003 clk  in  1  clock; reset rst, synchronous, active-high; clock clk.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 mem_valid_i  in  1  MEM-stage instruction valid.
REQ-006 mem_pc_i  in  32  PC of MEM-stage instruction.
REQ-007 mem_delayslot_i  in  1  MEM instruction is in a branch delay slot.
REQ-008 mem_break_i / mem_syscall_i / mem_overflow_i / mem_ades_i / mem_adel_i / mem_eret_i  in  1 each  MEM-stage event requests.
REQ-009 mem_addr_i  in  32  faulting data address for AdEL/AdES.
REQ-010 cp0_status_i, cp0_cause_i, cp0_epc_i  in  32 each  current CP0 Status, Cause, EPC.
REQ-011 int_i  in  6  hardware interrupt lines; timer_int_i  in  1  CP0 timer interrupt.
REQ-012 exc_int_o / exc_break_o / exc_syscall_o / exc_overflow_o / exc_ades_o / exc_adel_o / exc_eret_o  out  1 each  one-cycle event pulses to CP0.
REQ-013 exc_delayslot_o  out  1; exc_pc_o  out  32; exc_badvaddr_o  out  32  event context to CP0.
REQ-014 stall_o  out  1  holds pipeline front; flush_o  out  1  kills IF..MEM contents.
REQ-015 redirect_valid_o  out  1; redirect_pc_o  out  32; redirect_ready_i  in  1  fetch redirect handshake.

Function
REQ-016 Interrupt pending SHALL be: (({int_i[5]|timer_int_i, int_i[4:0], cp0_cause_i[9:8]} & cp0_status_i[15:8]) != 0) && status[0] && !status[1].
REQ-017 Events SHALL be considered only when state==IDLE and mem_valid_i=1; otherwise ignored, not queued.
REQ-018 Priority, highest first: interrupt, break, syscall, overflow, AdES, AdEL, eret; exactly one event accepted per acceptance cycle.
REQ-019 stall_o SHALL be combinational: 1 in the acceptance cycle and in every non-IDLE state.
REQ-020 States: IDLE, FLUSH, REDIRECT.
REQ-021 IDLE + accepted event in cycle N -> FLUSH at N+1; the matching exc_*_o pulses high exactly in cycle N+1.
REQ-022 exc_pc_o, exc_delayslot_o, exc_badvaddr_o SHALL be registered from mem_pc_i, mem_delayslot_i, mem_addr_i at N and valid during the pulse; otherwise hold last value.
REQ-023 redirect_pc_o SHALL be latched at N: EXC_VECTOR for any exception/interrupt, cp0_epc_i for eret.
REQ-024 FLUSH: flush_o=1 for exactly FLUSH_CYCLES cycles via 4-bit down counter, then -> REDIRECT.
REQ-025 REDIRECT: redirect_valid_o=1, redirect_pc_o stable; on redirect_ready_i=1 the transfer completes and state -> IDLE next cycle.
REQ-026 redirect_ready_i SHALL be ignored outside REDIRECT.
REQ-027 Exception and eret simultaneously: exception wins, exc_eret_o not pulsed.
REQ-028 Interrupt has no mem_valid dependence beyond REQ-017; interrupt masked by EXL=1 or IE=0 SHALL not be taken.
REQ-029 Eret SHALL be performed regardless of EXL value.
REQ-030 Next event accepted no earlier than the cycle after REDIRECT exits.

Reset
REQ-031 rst=1 at any clock edge -> state IDLE, counter 0, all outputs 0 (except stall_o combinational, 0 with inputs idle), regardless of state in progress.
REQ-032 Reset mid-FLUSH or mid-REDIRECT SHALL drop redirect_valid_o without completing the transfer.

Verification
REQ-033 syscall, mem_pc_i=32'h80001000, delayslot=0 -> exc_syscall_o pulse N+1, exc_pc_o=32'h80001000, flush_o 2 cycles, redirect_pc_o=32'hBFC00380.
REQ-034 break+overflow+eret same cycle -> only exc_break_o pulses; redirect to EXC_VECTOR.
REQ-035 eret with cp0_epc_i=32'h80002004 -> exc_eret_o pulse, redirect_pc_o=32'h80002004.
REQ-036 status=32'h0000FF01, timer_int_i=1 with syscall -> exc_int_o only; same with status[1]=1 -> exc_syscall_o only.
REQ-037 redirect_ready_i low 5 cycles in REDIRECT -> redirect_valid_o/pc held 5 cycles, new syscall ignored, IDLE after ready.
REQ-038 rst asserted in FLUSH cycle 1 -> next cycle all outputs 0, state IDLE, no redirect.
